// File: rtl/mem_responder_pkg.sv
// Shared definitions for the uP16 memory responder: FSM state encodings, bus widths,
// bus direction constants and the out-of-range address test.
package mem_responder_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 16;

   localparam logic RDWR_READ  = 1'b0;
   localparam logic RDWR_WRITE = 1'b1;

   typedef enum logic [1:0] {
      ST_CLR  = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // Full-width compare so that high address bits never alias into the array.
   function automatic logic addr_oor(input logic [31:0] addr, input int unsigned depth);
      return addr >= depth;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU bus and host load port of the uP16 memory responder, with responder and requester views.
interface mem_responder_if
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              cpu_en;
   logic              cpu_rdwr;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;

   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic [DATA_W-1:0] host_rdata;
   logic              host_ack;
   logic              host_go;
   logic              host_stop;

   modport responder (
      input  cpu_en, cpu_rdwr, cpu_addr, cpu_wdata,
      input  host_req, host_we, host_addr, host_wdata, host_go, host_stop,
      output cpu_rdata, host_rdata, host_ack
   );

   modport requester (
      output cpu_en, cpu_rdwr, cpu_addr, cpu_wdata,
      output host_req, host_we, host_addr, host_wdata, host_go, host_stop,
      input  cpu_rdata, host_rdata, host_ack
   );
endinterface

// File: rtl/mem_responder_sram.sv
// Single-port word RAM, synchronous write and registered read; drop-in point for a hard SRAM macro.
module mem_responder_sram #(
   parameter int DEPTH  = 512,
   parameter int DATA_W = 16,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= wdata;
      if (re) rdata <= mem_q[addr];
   end
endmodule

// File: rtl/mem_responder.sv
// uP16 memory responder: CPU/host arbiter, CLR/LOAD/RUN FSM and CPU hold control.
// Define MEM_CLEAR_EN to zero the array in a CLR sweep after every reset.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 512
) (
   input  logic              clkin,
   input  logic              rst,
   mem_responder_if.responder bus,
   output logic              cpu_hold,
   output logic              oor_err,
   output logic [1:0]        state_o
);
   localparam int AW = $clog2(DEPTH);

   state_t            state_q, state_d;
   logic              cpu_acc, host_gnt, cpu_oor, host_oor;
   logic              sram_we, sram_re;
   logic [AW-1:0]     sram_addr;
   logic [DATA_W-1:0] sram_wdata, sram_rdata;
   logic              cpu_hold_q, ack_q, oor_q;
   logic              cpu_rd_q, cpu_rd_oor_q, host_rd_q, host_rd_oor_q;
   logic [DATA_W-1:0] cpu_keep_q, host_keep_q, cpu_rdata_w, host_rdata_w;
`ifdef MEM_CLEAR_EN
   logic [AW-1:0]     clr_cnt_q;
`endif

   assign cpu_oor  = addr_oor(32'(bus.cpu_addr), DEPTH);
   assign host_oor = addr_oor(32'(bus.host_addr), DEPTH);

   always_comb begin
      state_d  = state_q;
      cpu_acc  = 1'b0;
      host_gnt = 1'b0;
      case (state_q)
         ST_CLR: begin
`ifdef MEM_CLEAR_EN
            if (clr_cnt_q == AW'(DEPTH - 1)) state_d = ST_LOAD;
`else
            state_d = ST_LOAD;
`endif
         end
         ST_LOAD: begin
            host_gnt = bus.host_req && !ack_q;
            if (bus.host_go) state_d = ST_RUN;
         end
         ST_RUN: begin
            cpu_acc  = bus.cpu_en;
            host_gnt = bus.host_req && !ack_q && !bus.cpu_en;
            if (bus.host_stop) state_d = ST_LOAD;
         end
         default: state_d = ST_LOAD;
      endcase
      if (rst) begin
         cpu_acc  = 1'b0;
         host_gnt = 1'b0;
      end
   end

   // Single RAM port: clear sweep, then CPU, then host.
   always_comb begin
      sram_we    = 1'b0;
      sram_re    = 1'b0;
      sram_addr  = bus.cpu_addr[AW-1:0];
      sram_wdata = bus.cpu_wdata;
      if (state_q == ST_CLR) begin
`ifdef MEM_CLEAR_EN
         sram_we    = 1'b1;
         sram_addr  = clr_cnt_q;
         sram_wdata = '0;
`endif
      end else if (cpu_acc) begin
         sram_we = (bus.cpu_rdwr == RDWR_WRITE) && !cpu_oor;
         sram_re = (bus.cpu_rdwr == RDWR_READ) && !cpu_oor;
      end else if (host_gnt) begin
         sram_addr  = bus.host_addr[AW-1:0];
         sram_wdata = bus.host_wdata;
         sram_we    = bus.host_we && !host_oor;
         sram_re    = !bus.host_we && !host_oor;
      end
      if (rst) begin
         sram_we = 1'b0;
         sram_re = 1'b0;
      end
   end

   mem_responder_sram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_sram (
      .clk   (clkin),
      .we    (sram_we),
      .re    (sram_re),
      .addr  (sram_addr),
      .wdata (sram_wdata),
      .rdata (sram_rdata)
   );

   // RAM read port is shared, so each reader keeps its last word once the port moves on.
   assign cpu_rdata_w  = cpu_rd_q  ? (cpu_rd_oor_q  ? '0 : sram_rdata) : cpu_keep_q;
   assign host_rdata_w = host_rd_q ? (host_rd_oor_q ? '0 : sram_rdata) : host_keep_q;

   always_ff @(posedge clkin) begin
      if (rst) begin
`ifdef MEM_CLEAR_EN
         state_q <= ST_CLR;
`else
         state_q <= ST_LOAD;
`endif
         cpu_hold_q    <= 1'b1;
         ack_q         <= 1'b0;
         oor_q         <= 1'b0;
         cpu_rd_q      <= 1'b0;
         cpu_rd_oor_q  <= 1'b0;
         host_rd_q     <= 1'b0;
         host_rd_oor_q <= 1'b0;
         cpu_keep_q    <= '0;
         host_keep_q   <= '0;
      end else begin
         state_q       <= state_d;
         cpu_hold_q    <= (state_d != ST_RUN);
         ack_q         <= host_gnt;
         cpu_rd_q      <= cpu_acc && (bus.cpu_rdwr == RDWR_READ);
         cpu_rd_oor_q  <= cpu_oor;
         host_rd_q     <= host_gnt && !bus.host_we;
         host_rd_oor_q <= host_oor;
         if (cpu_rd_q)  cpu_keep_q  <= cpu_rdata_w;
         if (host_rd_q) host_keep_q <= host_rdata_w;
         if ((cpu_acc && cpu_oor) || (host_gnt && host_oor)) oor_q <= 1'b1;
      end
   end

`ifdef MEM_CLEAR_EN
   always_ff @(posedge clkin) begin
      if (rst)                    clr_cnt_q <= '0;
      else if (state_q == ST_CLR) clr_cnt_q <= clr_cnt_q + 1'b1;
   end
`endif

   assign bus.cpu_rdata  = cpu_rdata_w;
   assign bus.host_rdata = host_rdata_w;
   assign bus.host_ack   = ack_q;
   assign cpu_hold       = cpu_hold_q;
   assign oor_err        = oor_q;
   assign state_o        = state_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reset, host preload, CPU access, contention, range and stop/reset.
module tb_mem_responder;
   logic       clkin = 1'b0;
   logic       rst;
   logic       cpu_hold, oor_err;
   logic [1:0] state_o;
   int         n_vec = 0;
   int         n_err = 0;
   logic [15:0] rd;

   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;

   mem_responder_if bus ();

   mem_responder dut (
      .clkin    (clkin),
      .rst      (rst),
      .bus      (bus.responder),
      .cpu_hold (cpu_hold),
      .oor_err  (oor_err),
      .state_o  (state_o)
   );

   always #5 clkin = ~clkin;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   task automatic cpu_op(input logic wr, input logic [11:0] a, input logic [15:0] d);
      bus.cpu_en    = 1'b1;
      bus.cpu_rdwr  = wr;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
      tick();
      bus.cpu_en    = 1'b0;
   endtask

   task automatic host_xfer(input string tag, input logic we, input logic [11:0] a,
                            input logic [15:0] d, output logic [15:0] data);
      int n = 0;
      bus.host_req   = 1'b1;
      bus.host_we    = we;
      bus.host_addr  = a;
      bus.host_wdata = d;
      do begin
         tick();
         n++;
      end while (!bus.host_ack && n < 20);
      check_eq(tag, {31'b0, bus.host_ack}, 32'd1);
      data = bus.host_rdata;
      bus.host_req = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.cpu_en = 0; bus.cpu_rdwr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
      bus.host_go = 0; bus.host_stop = 0;
      tick(); tick();
      check_eq("rst_hold", {31'b0, cpu_hold}, 32'd1);
      check_eq("rst_cpu_rdata", {16'b0, bus.cpu_rdata}, 32'h0);
      check_eq("rst_host_ack", {31'b0, bus.host_ack}, 32'd0);
      check_eq("rst_host_rdata", {16'b0, bus.host_rdata}, 32'h0);
      check_eq("rst_oor", {31'b0, oor_err}, 32'd0);
      rst = 1'b0;
`ifdef MEM_CLEAR_EN
      for (int i = 0; i < 512; i++) tick();
      check_eq("clr_done_state", {30'b0, state_o}, {30'b0, S_LOAD});
      host_xfer("clr_rd_ack", 1'b0, 12'h003, 16'h0, rd);
      check_eq("clr_rd_data", {16'b0, rd}, 32'h0);
`else
      check_eq("rst_state", {30'b0, state_o}, {30'b0, S_LOAD});
`endif
      // Preload in LOAD, including the last in-range word.
      host_xfer("ld_w0_ack", 1'b1, 12'h000, 16'h7800, rd);
      host_xfer("ld_w5_ack", 1'b1, 12'h005, 16'h1234, rd);
      host_xfer("ld_w1ff_ack", 1'b1, 12'h1FF, 16'h0BAD, rd);
      host_xfer("ld_r5_ack", 1'b0, 12'h005, 16'h0, rd);
      check_eq("ld_r5_data", {16'b0, rd}, 32'h1234);
      host_xfer("ld_r1ff_ack", 1'b0, 12'h1FF, 16'h0, rd);
      check_eq("ld_r1ff_data", {16'b0, rd}, 32'h0BAD);
      check_eq("ld_oor_clear", {31'b0, oor_err}, 32'd0);
      check_eq("ld_hold", {31'b0, cpu_hold}, 32'd1);

      bus.host_go = 1'b1;
      tick();
      bus.host_go = 1'b0;
      check_eq("go_state", {30'b0, state_o}, {30'b0, S_RUN});
      check_eq("go_hold", {31'b0, cpu_hold}, 32'd0);

      cpu_op(1'b0, 12'h000, 16'h0);
      check_eq("cpu_rd0", {16'b0, bus.cpu_rdata}, 32'h7800);
      tick();
      check_eq("cpu_rd0_hold", {16'b0, bus.cpu_rdata}, 32'h7800);
      cpu_op(1'b1, 12'h010, 16'hBEEF);
      check_eq("cpu_wr_keeps_rdata", {16'b0, bus.cpu_rdata}, 32'h7800);
      cpu_op(1'b0, 12'h010, 16'h0);
      check_eq("cpu_rd10", {16'b0, bus.cpu_rdata}, 32'hBEEF);

      // Contention: CPU busy for 3 cycles, host read waits.
      bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 12'h005;
      bus.cpu_en = 1'b1; bus.cpu_rdwr = 1'b0; bus.cpu_addr = 12'h000;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq($sformatf("cont_noack%0d", i), {31'b0, bus.host_ack}, 32'd0);
      end
      bus.cpu_en = 1'b0;
      tick();
      check_eq("cont_ack", {31'b0, bus.host_ack}, 32'd1);
      check_eq("cont_rdata", {16'b0, bus.host_rdata}, 32'h1234);
      check_eq("cont_cpu_rdata", {16'b0, bus.cpu_rdata}, 32'h7800);
      bus.host_req = 1'b0;
      tick();
      check_eq("cont_ack_pulse", {31'b0, bus.host_ack}, 32'd0);

      // Host write in RUN while CPU idle, then CPU reads it.
      host_xfer("run_w20_ack", 1'b1, 12'h020, 16'h5A5A, rd);
      cpu_op(1'b0, 12'h020, 16'h0);
      check_eq("run_cpu_rd20", {16'b0, bus.cpu_rdata}, 32'h5A5A);

      // Out of range: read 0, write dropped, no alias onto 0x000.
      cpu_op(1'b0, 12'h200, 16'h0);
      check_eq("oor_rd_data", {16'b0, bus.cpu_rdata}, 32'h0);
      check_eq("oor_flag", {31'b0, oor_err}, 32'd1);
      cpu_op(1'b1, 12'h200, 16'hAAAA);
      cpu_op(1'b0, 12'h000, 16'h0);
      check_eq("oor_no_alias", {16'b0, bus.cpu_rdata}, 32'h7800);
      host_xfer("oor_host_ack", 1'b0, 12'hFFF, 16'h0, rd);
      check_eq("oor_host_rd", {16'b0, rd}, 32'h0);
      check_eq("oor_sticky", {31'b0, oor_err}, 32'd1);
      cpu_op(1'b0, 12'h020, 16'h0);

      // Stop wins over same-cycle go.
      bus.host_stop = 1'b1; bus.host_go = 1'b1;
      tick();
      bus.host_stop = 1'b0; bus.host_go = 1'b0;
      check_eq("stop_state", {30'b0, state_o}, {30'b0, S_LOAD});
      check_eq("stop_hold", {31'b0, cpu_hold}, 32'd1);
      cpu_op(1'b1, 12'h000, 16'hDEAD);
      cpu_op(1'b0, 12'h010, 16'h0);
      check_eq("load_cpu_rd_ignored", {16'b0, bus.cpu_rdata}, 32'h5A5A);
      host_xfer("load_r0_ack", 1'b0, 12'h000, 16'h0, rd);
      check_eq("load_cpu_wr_ignored", {16'b0, rd}, 32'h7800);

      // Reset with a host write pending: no ack, write discarded.
      bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 12'h005; bus.host_wdata = 16'h9999;
      rst = 1'b1;
      tick();
      bus.host_req = 1'b0;
      rst = 1'b0;
      check_eq("rstmid_noack0", {31'b0, bus.host_ack}, 32'd0);
      tick();
      check_eq("rstmid_noack1", {31'b0, bus.host_ack}, 32'd0);
      check_eq("rstmid_oor", {31'b0, oor_err}, 32'd0);
      check_eq("rstmid_hold", {31'b0, cpu_hold}, 32'd1);
`ifndef MEM_CLEAR_EN
      host_xfer("rstmid_r5_ack", 1'b0, 12'h005, 16'h0, rd);
      check_eq("rstmid_r5_data", {16'b0, rd}, 32'h1234);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
